// File: rtl/instr_fetch.sv
// Instruction fetch unit: a word-addressed instruction store with an asynchronous
// read port at the PC and a synchronous load port. A two-state sequencer (run/halt)
// advances the PC and stops when it fetches the halt word. It also counts the
// instructions it issues.
module instr_fetch #(
  parameter int unsigned       ISIZE     = 32,
  parameter int unsigned       ASIZE     = 8,
  parameter logic [ISIZE-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [ASIZE-1:0] redirect_pc,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [ISIZE-1:0] wr_data,
  output logic [ISIZE-1:0] instr_out,
  output logic [ASIZE-1:0] pc_out,
  output logic             valid,
  output logic             halted,
  output logic [15:0]      fetch_count
);

  localparam int unsigned Depth = 2 ** ASIZE;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  logic [ISIZE-1:0] mem [Depth];
  state_e           state_q;
  logic [ASIZE-1:0] pc_q;
  logic [15:0]      cnt_q;
  logic [ISIZE-1:0] cur_word;
  logic             is_halt_word;

  // Instruction store load port. Reset does not touch it, so a program can be
  // loaded while the sequencer is held in reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read at the PC. A same-cycle write to this address only shows
  // up after the edge.
  always_comb begin
    cur_word     = mem[pc_q];
    is_halt_word = (cur_word == HALT_WORD);
  end

  // Sequencer. The priority order is reset, then redirect, then stall, then halt
  // detect, then increment. Every issued fetch counts, including the halt word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else if (redirect) begin
      state_q <= StRun;
      pc_q    <= redirect_pc;
    end else if (state_q == StRun && !stall) begin
      if (cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (is_halt_word) begin
        state_q <= StHalt;
      end else begin
        pc_q <= pc_q + ASIZE'(1);
      end
    end
  end

  // In halt the unit issues a NOP and marks it invalid.
  always_comb begin
    instr_out   = (state_q == StRun) ? cur_word : '0;
    valid       = (state_q == StRun);
    halted      = (state_q == StHalt);
    pc_out      = pc_q;
    fetch_count = cnt_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. It keeps a shadow copy of the instruction
// store. Expected fetches go into a queue when the stimulus is driven and are
// checked when the DUT presents them.
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic        valid;
  logic        halted;
  logic [15:0] fetch_count;

  int          nchecks = 0;
  int          nerr = 0;
  logic [31:0] mdl_mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;

  instr_fetch #(
    .ISIZE    (32),
    .ASIZE    (8),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .valid      (valid),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mdl_mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Pop the next expected fetch and compare it with the word presented now.
  task automatic pop_check(input string name);
    nchecks++;
    if (exp_q.size() == 0) begin
      nerr++; $display("FAIL %s: scoreboard empty, instr_out=%h", name, instr_out);
    end else begin
      exp_w = exp_q.pop_front();
      if (instr_out !== exp_w) begin
        nerr++; $display("FAIL %s: instr_out=%h expected %h", name, instr_out, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) write_word(8'(i), 32'h1000_0000 | 32'(i));
    write_word(8'd0, 32'd11);
    write_word(8'd1, 32'd22);
    write_word(8'd2, 32'd33);
    write_word(8'd3, HALT);
    nchecks++; if (pc_out !== 8'd0) begin nerr++; $display("FAIL reset_pc: %h expected 00", pc_out); end
    nchecks++; if (valid !== 1'b1) begin nerr++; $display("FAIL reset_valid: %b expected 1", valid); end
    nchecks++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted: %b expected 0", halted); end
    nchecks++; if (fetch_count !== 16'd0) begin nerr++; $display("FAIL reset_count: %h expected 0", fetch_count); end
    exp_q.push_back(mdl_mem[0]);
    pop_check("reset_instr");
  endtask

  task automatic test_sequence();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mdl_mem[i]);
    for (int i = 0; i < 4; i++) begin
      pop_check("seq_instr");
      nchecks++; if (valid !== 1'b1) begin nerr++; $display("FAIL seq_valid: %b expected 1", valid); end
      tick();
    end
    nchecks++; if (halted !== 1'b1) begin nerr++; $display("FAIL seq_halted: %b expected 1", halted); end
    nchecks++; if (valid !== 1'b0) begin nerr++; $display("FAIL seq_valid_halt: %b expected 0", valid); end
    nchecks++; if (instr_out !== 32'd0) begin nerr++; $display("FAIL seq_nop: %h expected 0", instr_out); end
    nchecks++; if (pc_out !== 8'd3) begin nerr++; $display("FAIL seq_pc: %h expected 03", pc_out); end
    nchecks++; if (fetch_count !== 16'd4) begin nerr++; $display("FAIL seq_count: %0d expected 4", fetch_count); end
  endtask

  task automatic test_stall();
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd22);
      tick();
      pop_check("stall_instr");
      nchecks++; if (fetch_count !== 16'd1) begin nerr++; $display("FAIL stall_count: %0d expected 1", fetch_count); end
      nchecks++; if (pc_out !== 8'd1) begin nerr++; $display("FAIL stall_pc: %h expected 01", pc_out); end
    end
    stall = 1'b0;
    tick();
    nchecks++; if (pc_out !== 8'd2) begin nerr++; $display("FAIL stall_release_pc: %h expected 02", pc_out); end
    nchecks++; if (fetch_count !== 16'd2) begin nerr++; $display("FAIL stall_release_count: %0d expected 2", fetch_count); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
    exp_q.push_back(mdl_mem[8'h40]);
    tick();
    redirect = 1'b0; stall = 1'b0;
    nchecks++; if (pc_out !== 8'h40) begin nerr++; $display("FAIL redir_pc: %h expected 40", pc_out); end
    pop_check("redir_instr");
    nchecks++; if (fetch_count !== 16'd2) begin nerr++; $display("FAIL redir_count: %0d expected 2", fetch_count); end
    redirect = 1'b1; redirect_pc = 8'h03; tick(); redirect = 1'b0;
    tick();
    nchecks++; if (halted !== 1'b1) begin nerr++; $display("FAIL redir_to_halt: %b expected 1", halted); end
    nchecks++; if (fetch_count !== 16'd3) begin nerr++; $display("FAIL halt_count: %0d expected 3", fetch_count); end
    stall = 1'b1; tick(); stall = 1'b0; tick();
    nchecks++; if (halted !== 1'b1 || pc_out !== 8'd3) begin
      nerr++; $display("FAIL halt_hold: halted=%b pc=%h expected 1/03", halted, pc_out);
    end
    nchecks++; if (fetch_count !== 16'd3) begin nerr++; $display("FAIL halt_hold_count: %0d expected 3", fetch_count); end
    redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
    exp_q.push_back(mdl_mem[8'h40]);
    tick();
    redirect = 1'b0; stall = 1'b0;
    nchecks++; if (halted !== 1'b0 || valid !== 1'b1) begin
      nerr++; $display("FAIL halt_exit: halted=%b valid=%b expected 0/1", halted, valid);
    end
    nchecks++; if (pc_out !== 8'h40) begin nerr++; $display("FAIL halt_exit_pc: %h expected 40", pc_out); end
    pop_check("halt_exit_instr");
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hFF;
    exp_q.push_back(mdl_mem[8'hFF]);
    tick();
    redirect = 1'b0;
    nchecks++; if (pc_out !== 8'hFF) begin nerr++; $display("FAIL wrap_pc_ff: %h expected ff", pc_out); end
    pop_check("wrap_instr_ff");
    exp_q.push_back(mdl_mem[0]);
    tick();
    nchecks++; if (pc_out !== 8'h00) begin nerr++; $display("FAIL wrap_pc_00: %h expected 00", pc_out); end
    pop_check("wrap_instr_00");
  endtask

  task automatic test_write_same_pc();
    redirect = 1'b1; redirect_pc = 8'd2; tick(); redirect = 1'b0;
    stall = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'h5A;
    exp_q.push_back(mdl_mem[2]);
    pop_check("wr_old_word");
    mdl_mem[2] = 32'h5A;
    exp_q.push_back(32'h5A);
    tick();
    wr_en = 1'b0;
    pop_check("wr_new_word");
    nchecks++; if (pc_out !== 8'd2) begin nerr++; $display("FAIL wr_pc: %h expected 02", pc_out); end
    stall = 1'b0;
    redirect = 1'b1; redirect_pc = 8'd3; tick(); redirect = 1'b0;
    tick();
    nchecks++; if (halted !== 1'b1) begin nerr++; $display("FAIL pre_rst_halt: %b expected 1", halted); end
    rst = 1'b1;
    exp_q.push_back(mdl_mem[0]);
    tick();
    nchecks++; if (pc_out !== 8'd0 || halted !== 1'b0 || valid !== 1'b1) begin
      nerr++; $display("FAIL rst_from_halt: pc=%h halted=%b valid=%b expected 00/0/1", pc_out, halted, valid);
    end
    pop_check("rst_from_halt_instr");
    rst = 1'b0;
    redirect = 1'b1; redirect_pc = 8'd2;
    exp_q.push_back(32'h5A);
    tick();
    redirect = 1'b0;
    pop_check("mem_intact");
  endtask

  task automatic test_saturate();
    write_word(8'd3, 32'd33);
    rst = 1'b1; tick(); rst = 1'b0;
    nchecks++; if (fetch_count !== 16'd0) begin nerr++; $display("FAIL sat_start: %0d expected 0", fetch_count); end
    repeat (65534) tick();
    nchecks++; if (fetch_count !== 16'hFFFE) begin nerr++; $display("FAIL sat_fffe: %h expected fffe", fetch_count); end
    tick();
    nchecks++; if (fetch_count !== 16'hFFFF) begin nerr++; $display("FAIL sat_ffff: %h expected ffff", fetch_count); end
    repeat (3) tick();
    nchecks++; if (fetch_count !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold: %h expected ffff", fetch_count); end
    nchecks++; if (valid !== 1'b1) begin nerr++; $display("FAIL sat_valid: %b expected 1", valid); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_wrap();
    test_write_same_pc();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ISIZE, default 32, instruction width in bits.
REQ-002 Parameter ASIZE, default 8, word-address (PC) width; memory depth SHALL be 2**ASIZE words.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that halts fetch.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 stall  input  1  hold PC; re-present the current instruction.
REQ-007 redirect  input  1  branch/jump taken; load PC from redirect_pc.
REQ-008 redirect_pc  input  ASIZE  redirect target word address.
REQ-009 wr_en  input  1  instruction-memory load strobe.
REQ-010 wr_addr  input  ASIZE  load word address.
REQ-011 wr_data  input  ISIZE  load data.
REQ-012 instr_out  output  ISIZE  fetched instruction to the IF/ID register; combinational from PC and memory.
REQ-013 pc_out  output  ASIZE  current PC.
REQ-014 valid  output  1  instr_out is a real fetch.
REQ-015 halted  output  1  fetch unit is in HALT.
REQ-016 fetch_count  output  16  number of instructions issued, saturating.

Function
REQ-017 Internal storage: 2**ASIZE x ISIZE array, asynchronous read at PC, synchronous write.
REQ-018 Two states SHALL exist: RUN and HALT.
REQ-019 RUN: instr_out = mem[pc], valid = 1, halted = 0.
REQ-020 HALT: instr_out = 0 (NOP), valid = 0, halted = 1, PC frozen.
REQ-021 Per-edge priority outside reset: redirect > stall > halt detect > increment.
REQ-022 redirect = 1 in either state: PC <= redirect_pc, state <= RUN; stall is ignored in that cycle.
REQ-023 RUN, stall = 1, redirect = 0: PC, state and fetch_count SHALL hold.
REQ-024 RUN, no stall, no redirect, mem[pc] == HALT_WORD: state <= HALT, PC holds; the halt word is presented once with valid = 1 and counted.
REQ-025 RUN, no stall, no redirect, mem[pc] != HALT_WORD: PC <= PC + 1, modulo 2**ASIZE (all-ones wraps to 0).
REQ-026 HALT with redirect = 0: no state change regardless of stall.
REQ-027 fetch_count SHALL increment on every edge with state == RUN, stall = 0 and redirect = 0, and saturate at 16'hFFFF.
REQ-028 wr_en = 1: mem[wr_addr] <= wr_data at the edge.
REQ-029 A write to wr_addr == pc SHALL leave instr_out showing the old word in that cycle and the new word from the next cycle.
REQ-030 Writes SHALL be accepted in any state and during reset.
REQ-031 Latency: a redirect asserted in cycle N SHALL produce instr_out = mem[redirect_pc] in cycle N+1.

Reset
REQ-032 rst = 1 at an edge: PC <= 0, state <= RUN, fetch_count <= 0; this overrides redirect, stall and halt detect.
REQ-033 Reset SHALL NOT clear instruction memory.
REQ-034 After reset: valid = 1, halted = 0, instr_out = mem[0].
REQ-035 Reset during HALT or stall SHALL return the unit to RUN at PC 0 on the same edge.

Verification
REQ-036 Load mem[0..3] = 11,22,33,HALT_WORD; release rst -> instr_out sequence 11,22,33,HALT_WORD; then halted = 1, valid = 0, instr_out = 0, pc_out = 3, fetch_count = 4.
REQ-037 stall held for 3 cycles at pc_out = 1 -> instr_out stays 22 and fetch_count is unchanged; release -> pc_out = 2 on the next edge.
REQ-038 redirect = 1, redirect_pc = 8'h40 together with stall = 1 -> pc_out = 8'h40 on the next cycle; also from HALT -> halted = 0, valid = 1.
REQ-039 Redirect to 8'hFF, mem[8'hFF] non-halt -> pc_out goes 8'hFF then 8'h00.
REQ-040 wr_en to the current pc with data 5A while stalled -> old word this cycle, 5A the next cycle; rst asserted during HALT -> pc_out = 0, halted = 0, memory contents intact.
REQ-041 Force fetch_count to 16'hFFFE via a long run -> it reads 16'hFFFF after one more fetch and stays there.
